alu_stage: RTL and testbench
============================

Name: alu_stage

Overview:
- Consumer end of the operand-select path: takes the `alu_A`/`alu_B` pair plus an operation code and computes the RV64I integer ALU result.
- Registers the result into a two-entry output buffer (output register plus skid register) with valid/ready handshakes on both sides.
- Sits between operand selection and the EX/MEM boundary; lets downstream back-pressure stall execute without a combinational ready path.

Parameters:
- DATA_WIDTH, 64, operand and result width; the W-variant ops require 64.
- OP_WIDTH, 5, width of the ALU operation code.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- flush_i  input  1  synchronous pipeline kill (branch redirect); drops all held and incoming work.
- in_valid_i  input  1  operand bundle valid.
- in_ready_o  output  1  stage can accept a bundle this cycle; registered.
- alu_A_i  input  DATA_WIDTH  first operand.
- alu_B_i  input  DATA_WIDTH  second operand.
- alu_op_i  input  OP_WIDTH  operation code (package enum).
- rd_i  input  5  destination register tag, carried alongside the result.
- out_valid_o  output  1  result valid.
- out_ready_i  input  1  downstream accepts the result.
- result_o  output  DATA_WIDTH  ALU result.
- rd_o  output  5  destination tag of `result_o`.

Behaviour:
- Reset (rst=1 at an edge):
  - out_valid_o=0, in_ready_o=1, result_o=0, rd_o=0.
  - Skid register empty.
  - Reset mid-transfer discards all held results.
- Flush (flush_i=1 at an edge): same state effect as reset. When flush_i and in_valid_i are both high, flush wins and the input is dropped.
- Accept: in_valid_i & in_ready_o at an edge. Result is computed combinationally from the inputs and registered; latency is 1 cycle.
- Ops:
  - ADD, SUB, XOR, OR, AND: full 64-bit.
  - SLL, SRL, SRA: use B[5:0].
  - SLT (signed) and SLTU (unsigned): produce 0 or 1.
  - PASS_B: result = B (LUI).
  - ADDW, SUBW: compute on [31:0], then sign-extend bit 31.
  - SLLW, SRLW, SRAW: use B[4:0] and operate on A[31:0]; SRLW zero-fills from bit 31 before sign-extension.
  - Undefined codes: result 0, still handshaken.
  - All add/sub arithmetic wraps modulo 2^width; there are no overflow flags.
- Buffer states (output register O, skid S):
  - EMPTY (O invalid):
    - Accept → ONE.
  - ONE (O valid, S empty):
    - Accept & out_ready_i → O reloads with the new result; stays ONE.
    - Accept & !out_ready_i → new result goes to S; → FULL.
    - No accept & out_ready_i → EMPTY.
  - FULL (O valid, S valid):
    - in_ready_o=0.
    - out_ready_i → S moves to O, S empties; → ONE. A new bundle may not be accepted in this same cycle, because in_ready_o was 0.
- in_ready_o = !S.valid, registered. No combinational path from out_ready_i to in_ready_o.
- result_o and rd_o hold stable while out_valid_o=1 and out_ready_i=0.
- Ordering: results leave in acceptance order. No result is dropped or duplicated except on flush or reset.

Decomposition:
- Package `alu_pkg` holds:
  - the `alu_op_e` enum (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, ADDW, SUBW, SLLW, SRLW, SRAW, PASS_B);
  - OP_WIDTH;
  - constant SHAMT64=6, SHAMT32=5.
- One sub-module, `alu_core`: purely combinational A/B/op → result.
- The stage wrapper owns the handshake and skid logic.

Test Plan:
- Reset then idle → out_valid_o=0, in_ready_o=1, result_o=0 for 5 cycles; hold rst 3 cycles mid-stream → all pending results lost.
- ADD with A=0xFFFF_FFFF_FFFF_FFFF, B=1, out_ready_i=1 → next cycle result_o=0, out_valid_o=1; SUB with A=0, B=1 → 0xFFFF_FFFF_FFFF_FFFF.
- ADDW with A=0x7FFF_FFFF, B=1 → 0xFFFF_FFFF_8000_0000. SRAW with A=0x8000_0000, B=0x3F → 0xFFFF_FFFF_FFFF_FFFF. SRL with A=0x8000_0000_0000_0000, B=63 → 1. SLT with A=-1, B=0 → 1, and SLTU with the same operands → 0.
- Back-pressure: out_ready_i=0 while 3 back-to-back bundles (rd 1, 2, 3) are offered → 2 accepted, in_ready_o=0 from the third cycle. Then out_ready_i=1 → rd 1, 2, 3 emerge in order with no loss or duplication.
- Flush in the FULL state with in_valid_i=1 → next cycle out_valid_o=0, in_ready_o=1, and the offered bundle never appears.
- Random stream with random out_ready_i over 10k ops, checked against a reference model → identical ordered results; in_ready_o never depends combinationally on out_ready_i.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared types and constants for the RV64I ALU stage.
//                Holds the ALU operation encoding, shift-amount widths and
//                the output-buffer state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int OP_WIDTH = 5;

    // Shift-amount widths for the 64-bit and 32-bit (W) shift families.
    localparam int SHAMT64 = 6;
    localparam int SHAMT32 = 5;

    typedef enum logic [OP_WIDTH-1:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_SLL    = 5'd2,
        ALU_SLT    = 5'd3,
        ALU_SLTU   = 5'd4,
        ALU_XOR    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_OR     = 5'd8,
        ALU_AND    = 5'd9,
        ALU_ADDW   = 5'd10,
        ALU_SUBW   = 5'd11,
        ALU_SLLW   = 5'd12,
        ALU_SRLW   = 5'd13,
        ALU_SRAW   = 5'd14,
        ALU_PASS_B = 5'd15
    } alu_op_e;

    // Occupancy of the output register (O) and skid register (S).
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,   // O invalid
        BUF_ONE   = 2'd1,   // O valid, S empty
        BUF_FULL  = 2'd2    // O valid, S valid
    } buf_state_e;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
//  Module      : alu_core
//  Description : Purely combinational RV64I integer ALU.
//  Ports       : a_i, b_i  - operands (DATA_WIDTH)
//                op_i      - operation code (alu_op_e encoding)
//                result_o  - result (DATA_WIDTH); 0 for undefined codes
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_core #(
    parameter int DATA_WIDTH = 64,
    parameter int OP_WIDTH   = alu_pkg::OP_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic [OP_WIDTH-1:0]   op_i,
    output logic [DATA_WIDTH-1:0] result_o
);
    import alu_pkg::*;

    logic [SHAMT64-1:0] w_shamt64;
    logic [SHAMT32-1:0] w_shamt32;
    logic [31:0]        w_a32;
    logic [31:0]        w_b32;
    logic [31:0]        w_addw;
    logic [31:0]        w_subw;
    logic [31:0]        w_sllw;
    logic [31:0]        w_srlw;
    logic [31:0]        w_sraw;
    logic               w_lt_s;
    logic               w_lt_u;

    assign w_shamt64 = b_i[SHAMT64-1:0];
    assign w_shamt32 = b_i[SHAMT32-1:0];
    assign w_a32     = a_i[31:0];
    assign w_b32     = b_i[31:0];

    // W-variants operate on the low word only; the upper half of A is ignored.
    // SRLW zero-fills from bit 31, so the sign extension below may still
    // produce ones when the shift amount is zero.
    assign w_addw = w_a32 + w_b32;
    assign w_subw = w_a32 - w_b32;
    assign w_sllw = w_a32 << w_shamt32;
    assign w_srlw = w_a32 >> w_shamt32;
    assign w_sraw = $signed(w_a32) >>> w_shamt32;

    assign w_lt_s = $signed(a_i) < $signed(b_i);
    assign w_lt_u = a_i < b_i;

    function automatic logic [DATA_WIDTH-1:0] sext32(input logic [31:0] v);
        return {{(DATA_WIDTH-32){v[31]}}, v};
    endfunction

    always_comb begin
        result_o = '0;
        case (op_i)
            ALU_ADD:    result_o = a_i + b_i;
            ALU_SUB:    result_o = a_i - b_i;
            ALU_SLL:    result_o = a_i << w_shamt64;
            ALU_SLT:    result_o = {{(DATA_WIDTH-1){1'b0}}, w_lt_s};
            ALU_SLTU:   result_o = {{(DATA_WIDTH-1){1'b0}}, w_lt_u};
            ALU_XOR:    result_o = a_i ^ b_i;
            ALU_SRL:    result_o = a_i >> w_shamt64;
            ALU_SRA:    result_o = $signed(a_i) >>> w_shamt64;
            ALU_OR:     result_o = a_i | b_i;
            ALU_AND:    result_o = a_i & b_i;
            ALU_ADDW:   result_o = sext32(w_addw);
            ALU_SUBW:   result_o = sext32(w_subw);
            ALU_SLLW:   result_o = sext32(w_sllw);
            ALU_SRLW:   result_o = sext32(w_srlw);
            ALU_SRAW:   result_o = sext32(w_sraw);
            ALU_PASS_B: result_o = b_i;
            default:    result_o = '0;
        endcase
    end

endmodule : alu_core
`default_nettype wire

// File: rtl/alu_stage.sv
`default_nettype none
// ============================================================================
//  Module      : alu_stage
//  Description : ALU execute stage with a two-entry (output + skid) result
//                buffer and valid/ready handshakes on both sides.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                flush_i         - pipeline kill; drops held and incoming work
//                in_valid_i/in_ready_o  - upstream handshake (ready registered)
//                alu_A_i, alu_B_i, alu_op_i, rd_i - operand bundle
//                out_valid_o/out_ready_i - downstream handshake
//                result_o, rd_o  - registered result and its destination tag
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_stage #(
    parameter int DATA_WIDTH = 64,
    parameter int OP_WIDTH   = alu_pkg::OP_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] alu_A_i,
    input  logic [DATA_WIDTH-1:0] alu_B_i,
    input  logic [OP_WIDTH-1:0]   alu_op_i,
    input  logic [4:0]            rd_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic [4:0]            rd_o
);
    import alu_pkg::*;

    buf_state_e            state_q,       state_d;
    logic                  in_ready_q,    in_ready_d;
    logic [DATA_WIDTH-1:0] out_result_q,  out_result_d;
    logic [4:0]            out_rd_q,      out_rd_d;
    logic [DATA_WIDTH-1:0] skid_result_q, skid_result_d;
    logic [4:0]            skid_rd_q,     skid_rd_d;

    logic [DATA_WIDTH-1:0] w_alu_result;
    logic                  w_accept;

    alu_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .OP_WIDTH   (OP_WIDTH)
    ) u_alu_core (
        .a_i      (alu_A_i),
        .b_i      (alu_B_i),
        .op_i     (alu_op_i),
        .result_o (w_alu_result)
    );

    // in_ready_q is a flop, so acceptance never depends combinationally on
    // out_ready_i.
    assign w_accept = in_valid_i & in_ready_q;

    always_comb begin
        state_d       = state_q;
        out_result_d  = out_result_q;
        out_rd_d      = out_rd_q;
        skid_result_d = skid_result_q;
        skid_rd_d     = skid_rd_q;

        if (flush_i) begin
            // Flush wins over a simultaneous input; the bundle is dropped.
            state_d       = BUF_EMPTY;
            out_result_d  = '0;
            out_rd_d      = '0;
            skid_result_d = '0;
            skid_rd_d     = '0;
        end else begin
            case (state_q)
                BUF_EMPTY: begin
                    if (w_accept) begin
                        out_result_d = w_alu_result;
                        out_rd_d     = rd_i;
                        state_d      = BUF_ONE;
                    end
                end
                BUF_ONE: begin
                    if (w_accept && out_ready_i) begin
                        out_result_d = w_alu_result;
                        out_rd_d     = rd_i;
                    end else if (w_accept) begin
                        skid_result_d = w_alu_result;
                        skid_rd_d     = rd_i;
                        state_d       = BUF_FULL;
                    end else if (out_ready_i) begin
                        state_d = BUF_EMPTY;
                    end
                end
                BUF_FULL: begin
                    // in_ready_q is low here, so no accept can coincide.
                    if (out_ready_i) begin
                        out_result_d = skid_result_q;
                        out_rd_d     = skid_rd_q;
                        state_d      = BUF_ONE;
                    end
                end
                default: state_d = BUF_EMPTY;
            endcase
        end

        in_ready_d = (state_d != BUF_FULL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= BUF_EMPTY;
            in_ready_q    <= 1'b1;
            out_result_q  <= '0;
            out_rd_q      <= '0;
            skid_result_q <= '0;
            skid_rd_q     <= '0;
        end else begin
            state_q       <= state_d;
            in_ready_q    <= in_ready_d;
            out_result_q  <= out_result_d;
            out_rd_q      <= out_rd_d;
            skid_result_q <= skid_result_d;
            skid_rd_q     <= skid_rd_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = (state_q != BUF_EMPTY);
    assign result_o    = out_result_q;
    assign rd_o        = out_rd_q;

endmodule : alu_stage
`default_nettype wire

// File: tb/tb_alu_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_stage
//  Description : Self-checking testbench for alu_stage: directed ALU vectors,
//                back-pressure, flush, reset and an ordered random stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_stage;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [63:0] alu_A_i;
    logic [63:0] alu_B_i;
    logic [4:0]  alu_op_i;
    logic [4:0]  rd_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [63:0] result_o;
    logic [4:0]  rd_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_stage #(
        .DATA_WIDTH (64),
        .OP_WIDTH   (5)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .alu_A_i     (alu_A_i),
        .alu_B_i     (alu_B_i),
        .alu_op_i    (alu_op_i),
        .rd_i        (rd_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .result_o    (result_o),
        .rd_o        (rd_o)
    );

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic offer(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] rd);
        in_valid_i = 1'b1;
        alu_op_i   = op;
        alu_A_i    = a;
        alu_B_i    = b;
        rd_i       = rd;
    endtask

    // One op through an idle stage with out_ready_i=1; result due next cycle.
    task automatic run_op(input string tag, input logic [4:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [4:0] rd, input logic [63:0] exp);
        offer(op, a, b, rd);
        out_ready_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        check_value({tag, " valid"}, {63'd0, out_valid_o}, 64'd1);
        check_value(tag, result_o, exp);
        check_value({tag, " rd"}, {59'd0, rd_o}, {59'd0, rd});
        tick();
    endtask

    function automatic logic [63:0] model(input logic [4:0] op, input logic [63:0] a,
                                          input logic [63:0] b);
        case (op)
            5'd0:    return a + b;   // ADD
            5'd1:    return a - b;   // SUB
            5'd5:    return a ^ b;   // XOR
            default: return b;       // PASS_B
        endcase
    endfunction

    initial begin
        logic [68:0] sb[$];
        logic [68:0] head;
        logic [4:0]  rop;
        logic        ir_before;
        int          pushed;
        int          cycles;

        rst = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
        alu_A_i = '0; alu_B_i = '0; alu_op_i = '0; rd_i = '0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state held while idle.
        for (int i = 0; i < 5; i++) begin
            tick();
            check_value("idle valid", {63'd0, out_valid_o}, 64'd0);
            check_value("idle ready", {63'd0, in_ready_o}, 64'd1);
            check_value("idle result", result_o, 64'd0);
            check_value("idle rd", {59'd0, rd_o}, 64'd0);
        end

        // Directed ALU vectors.
        run_op("ADD wrap",   ALU_ADD,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd1, 64'd0);
        run_op("SUB wrap",   ALU_SUB,  64'd0, 64'd1, 5'd2, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("ADDW ovf",   ALU_ADDW, 64'h7FFF_FFFF, 64'd1, 5'd3, 64'hFFFF_FFFF_8000_0000);
        run_op("SRAW 63",    ALU_SRAW, 64'h8000_0000, 64'h3F, 5'd4, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("SRL 63",     ALU_SRL,  64'h8000_0000_0000_0000, 64'd63, 5'd5, 64'd1);
        run_op("SLT neg",    ALU_SLT,  64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 5'd6, 64'd1);
        run_op("SLTU neg",   ALU_SLTU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 5'd7, 64'd0);
        run_op("SRA 4",      ALU_SRA,  64'h8000_0000_0000_0000, 64'd4, 5'd8, 64'hF800_0000_0000_0000);
        run_op("SLL 64",     ALU_SLL,  64'd1, 64'd64, 5'd9, 64'd1);
        run_op("SLLW 31",    ALU_SLLW, 64'd1, 64'd31, 5'd10, 64'hFFFF_FFFF_8000_0000);
        run_op("SRLW 31",    ALU_SRLW, 64'hFFFF_FFFF_8000_0000, 64'd31, 5'd11, 64'd1);
        run_op("SRLW 0",     ALU_SRLW, 64'h8000_0000, 64'd0, 5'd12, 64'hFFFF_FFFF_8000_0000);
        run_op("SUBW",       ALU_SUBW, 64'h1_0000_0000, 64'd1, 5'd13, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("XOR",        ALU_XOR,  64'hFF00_FF00_FF00_FF00, 64'h0F0F_0F0F_0F0F_0F0F, 5'd14,
               64'hF00F_F00F_F00F_F00F);
        run_op("OR",         ALU_OR,   64'hFF00_FF00_FF00_FF00, 64'h0F0F_0F0F_0F0F_0F0F, 5'd15,
               64'hFF0F_FF0F_FF0F_FF0F);
        run_op("AND",        ALU_AND,  64'hFF00_FF00_FF00_FF00, 64'h0F0F_0F0F_0F0F_0F0F, 5'd16,
               64'h0F00_0F00_0F00_0F00);
        run_op("PASS_B",     ALU_PASS_B, 64'd123, 64'hDEAD_BEEF_0000_1000, 5'd17,
               64'hDEAD_BEEF_0000_1000);
        run_op("undef op",   5'd20, 64'd5, 64'd7, 5'd18, 64'd0);

        // Back-pressure: three back-to-back bundles, downstream stalled.
        out_ready_i = 1'b0;
        offer(ALU_ADD, 64'd10, 64'd1, 5'd1);
        tick();
        check_value("bp o1 rd", {59'd0, rd_o}, 64'd1);
        check_value("bp o1 ready", {63'd0, in_ready_o}, 64'd1);
        offer(ALU_ADD, 64'd20, 64'd2, 5'd2);
        tick();
        check_value("bp full ready", {63'd0, in_ready_o}, 64'd0);
        check_value("bp full rd", {59'd0, rd_o}, 64'd1);
        offer(ALU_ADD, 64'd30, 64'd3, 5'd3);
        tick();
        check_value("bp stall ready", {63'd0, in_ready_o}, 64'd0);
        check_value("bp hold result", result_o, 64'd11);
        check_value("bp hold rd", {59'd0, rd_o}, 64'd1);
        out_ready_i = 1'b1;
        tick();
        check_value("bp pop1 rd", {59'd0, rd_o}, 64'd2);
        check_value("bp pop1 result", result_o, 64'd22);
        check_value("bp pop1 ready", {63'd0, in_ready_o}, 64'd1);
        tick();
        in_valid_i = 1'b0;
        check_value("bp pop2 rd", {59'd0, rd_o}, 64'd3);
        check_value("bp pop2 result", result_o, 64'd33);
        tick();
        check_value("bp drained", {63'd0, out_valid_o}, 64'd0);

        // Flush while FULL with a bundle offered.
        out_ready_i = 1'b0;
        offer(ALU_ADD, 64'd1, 64'd1, 5'd4);
        tick();
        offer(ALU_ADD, 64'd2, 64'd2, 5'd5);
        tick();
        check_value("fl full ready", {63'd0, in_ready_o}, 64'd0);
        flush_i = 1'b1;
        offer(ALU_ADD, 64'd7, 64'd7, 5'd7);
        tick();
        flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
        check_value("fl valid", {63'd0, out_valid_o}, 64'd0);
        check_value("fl ready", {63'd0, in_ready_o}, 64'd1);
        check_value("fl result", result_o, 64'd0);
        check_value("fl rd", {59'd0, rd_o}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_value("fl stays empty", {63'd0, out_valid_o}, 64'd0);
        end

        // Flush while ONE: the stage is ready, yet flush still drops the input.
        out_ready_i = 1'b0;
        offer(ALU_ADD, 64'd8, 64'd0, 5'd8);
        tick();
        flush_i = 1'b1;
        offer(ALU_ADD, 64'd9, 64'd0, 5'd9);
        tick();
        flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
        check_value("fl1 valid", {63'd0, out_valid_o}, 64'd0);
        tick();
        check_value("fl1 stays empty", {63'd0, out_valid_o}, 64'd0);

        // Reset held 3 cycles mid-stream.
        out_ready_i = 1'b0;
        offer(ALU_ADD, 64'd10, 64'd0, 5'd10);
        tick();
        offer(ALU_ADD, 64'd11, 64'd0, 5'd11);
        tick();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0; in_valid_i = 1'b0;
        check_value("rst valid", {63'd0, out_valid_o}, 64'd0);
        check_value("rst ready", {63'd0, in_ready_o}, 64'd1);
        check_value("rst result", result_o, 64'd0);
        out_ready_i = 1'b1;
        tick();
        check_value("rst stays empty", {63'd0, out_valid_o}, 64'd0);

        // Random stream with random back-pressure against a scoreboard.
        pushed = 0;
        cycles = 0;
        in_valid_i = 1'b0;
        while (pushed < 10000 && cycles < 60000) begin
            if ((cycles % 16) == 0) begin
                ir_before   = in_ready_o;
                out_ready_i = ~out_ready_i;
                #1;
                check_value("ready comb path", {63'd0, in_ready_o}, {63'd0, ir_before});
            end
            // A bundle is held stable until it is accepted.
            if (!in_valid_i || in_ready_o) begin
                case ($urandom_range(0, 3))
                    0:       rop = ALU_ADD;
                    1:       rop = ALU_SUB;
                    2:       rop = ALU_XOR;
                    default: rop = ALU_PASS_B;
                endcase
                in_valid_i = ($urandom_range(0, 3) != 0);
                alu_op_i   = rop;
                alu_A_i    = {$urandom, $urandom};
                alu_B_i    = {$urandom, $urandom};
                rd_i       = 5'($urandom);
            end
            out_ready_i = $urandom_range(0, 1) == 1;
            if (out_valid_o && out_ready_i) begin
                if (sb.size() == 0) begin
                    check_value("rnd underflow", 64'd1, 64'd0);
                end else begin
                    head = sb.pop_front();
                    check_value("rnd result", result_o, head[63:0]);
                    check_value("rnd rd", {59'd0, rd_o}, {59'd0, head[68:64]});
                end
            end
            if (in_valid_i && in_ready_o) begin
                sb.push_back({rd_i, model(alu_op_i, alu_A_i, alu_B_i)});
                pushed++;
            end
            tick();
            cycles++;
        end
        check_value("rnd pushed", 64'(pushed), 64'd10000);

        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        while (sb.size() > 0 && cycles < 60100) begin
            if (out_valid_o) begin
                head = sb.pop_front();
                check_value("drain result", result_o, head[63:0]);
                check_value("drain rd", {59'd0, rd_o}, {59'd0, head[68:64]});
            end
            tick();
            cycles++;
        end
        check_value("drain left", 64'(sb.size()), 64'd0);
        check_value("drain valid", {63'd0, out_valid_o}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_alu_stage
`default_nettype wire
